// File: rtl/edge_pkg.sv
// Shared types and widths for the edge threshold / statistics block.
package edge_pkg;

  localparam int EDGE_CNT_W = 20;
  localparam int COORD_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic logic [EDGE_CNT_W-1:0] edge_sat_inc(input logic [EDGE_CNT_W-1:0] v);
    return (v == {EDGE_CNT_W{1'b1}}) ? v : v + 20'd1;
  endfunction

endpackage

// File: rtl/edge_bbox_tracker.sv
// Min/max accumulator for the (row, col) coordinates of edge pixels in a frame.
module edge_bbox_tracker
  import edge_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               update,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] min_row,
  output logic [COORD_W-1:0] max_row,
  output logic [COORD_W-1:0] min_col,
  output logic [COORD_W-1:0] max_col
);

  logic [COORD_W-1:0] min_row_q, min_row_d, max_row_q, max_row_d;
  logic [COORD_W-1:0] min_col_q, min_col_d, max_col_q, max_col_d;
  logic               seen_q, seen_d;

  // The first edge of a frame seeds all four bounds; later edges widen them.
  always_comb begin
    min_row_d = min_row_q;
    max_row_d = max_row_q;
    min_col_d = min_col_q;
    max_col_d = max_col_q;
    seen_d    = seen_q;
    if (clear) begin
      min_row_d = {COORD_W{1'b0}};
      max_row_d = {COORD_W{1'b0}};
      min_col_d = {COORD_W{1'b0}};
      max_col_d = {COORD_W{1'b0}};
      seen_d    = 1'b0;
    end else if (update) begin
      seen_d = 1'b1;
      if (!seen_q) begin
        min_row_d = row;
        max_row_d = row;
        min_col_d = col;
        max_col_d = col;
      end else begin
        if (row < min_row_q) min_row_d = row; else min_row_d = min_row_q;
        if (row > max_row_q) max_row_d = row; else max_row_d = max_row_q;
        if (col < min_col_q) min_col_d = col; else min_col_d = min_col_q;
        if (col > max_col_q) max_col_d = col; else max_col_d = max_col_q;
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // Bound registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_row_q <= {COORD_W{1'b0}};
      max_row_q <= {COORD_W{1'b0}};
      min_col_q <= {COORD_W{1'b0}};
      max_col_q <= {COORD_W{1'b0}};
      seen_q    <= 1'b0;
    end else begin
      min_row_q <= min_row_d;
      max_row_q <= max_row_d;
      min_col_q <= min_col_d;
      max_col_q <= max_col_d;
      seen_q    <= seen_d;
    end
  end

  assign min_row = min_row_q;
  assign max_row = max_row_q;
  assign min_col = min_col_q;
  assign max_col = max_col_q;

endmodule

// File: rtl/edge_threshold_stats.sv
// Binarizes a gradient stream against a latched threshold and reports per-frame edge stats.
// Bounding-box tracking is built only when EDGE_BBOX_EN is defined.
module edge_threshold_stats
  import edge_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      threshold,
  input  logic [WIDTH-1:0]      pixel_in,
  input  logic                  valid_in,
  input  logic                  done_in,
  output logic [WIDTH-1:0]      pixel_out,
  output logic                  valid_out,
  output logic [EDGE_CNT_W-1:0] edge_count,
  output logic [COORD_W-1:0]    bbox_min_col,
  output logic [COORD_W-1:0]    bbox_max_col,
  output logic [COORD_W-1:0]    bbox_min_row,
  output logic [COORD_W-1:0]    bbox_max_row,
  output logic                  bbox_valid,
  output logic                  frame_err,
  output logic                  stats_valid
);

  localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(IMG_WIDTH - 3);
  localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(IMG_HEIGHT - 3);
  localparam logic [31:0]        FRAME_PIX = 32'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2));

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        thr_q, thr_d;
  logic [COORD_W-1:0]      col_q, col_d, row_q, row_d;
  logic [31:0]             pix_cnt_q, pix_cnt_d;
  logic [EDGE_CNT_W-1:0]   edge_acc_q, edge_acc_d;
  logic [WIDTH-1:0]        pixel_out_q, pixel_out_d;
  logic                    valid_out_q, valid_out_d;
  logic [EDGE_CNT_W-1:0]   edge_count_q, edge_count_d;
  logic                    frame_err_q, frame_err_d;
  logic                    stats_valid_q, stats_valid_d;
  logic                    clear_s, edge_s;

  assign clear_s = (state_q == ST_IDLE) && start;
  assign edge_s  = (state_q == ST_RUN) && valid_in && (pixel_in >= thr_q);

  // FSM, pixel path and frame accumulators; a pixel arriving with done_in is still counted.
  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    col_d         = col_q;
    row_d         = row_q;
    pix_cnt_d     = pix_cnt_q;
    edge_acc_d    = edge_acc_q;
    pixel_out_d   = pixel_out_q;
    valid_out_d   = 1'b0;
    edge_count_d  = edge_count_q;
    frame_err_d   = frame_err_q;
    stats_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          thr_d      = threshold;
          col_d      = {COORD_W{1'b0}};
          row_d      = {COORD_W{1'b0}};
          pix_cnt_d  = 32'd0;
          edge_acc_d = {EDGE_CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (valid_in) begin
          valid_out_d = 1'b1;
          pixel_out_d = edge_s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          pix_cnt_d   = (pix_cnt_q == 32'hFFFF_FFFF) ? pix_cnt_q : pix_cnt_q + 32'd1;
          edge_acc_d  = edge_s ? edge_sat_inc(edge_acc_q) : edge_acc_q;
          // Row holds at the last line so overrun pixels never alias back to row 0.
          if (col_q == LAST_COL) begin
            col_d = {COORD_W{1'b0}};
            row_d = (row_q == LAST_ROW) ? row_q : row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
        end else begin
          valid_out_d = 1'b0;
        end
        if (done_in) state_d = ST_REPORT; else state_d = ST_RUN;
      end
      ST_REPORT: begin
        edge_count_d  = edge_acc_q;
        frame_err_d   = (pix_cnt_q != FRAME_PIX);
        stats_valid_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      thr_q         <= {WIDTH{1'b0}};
      col_q         <= {COORD_W{1'b0}};
      row_q         <= {COORD_W{1'b0}};
      pix_cnt_q     <= 32'd0;
      edge_acc_q    <= {EDGE_CNT_W{1'b0}};
      pixel_out_q   <= {WIDTH{1'b0}};
      valid_out_q   <= 1'b0;
      edge_count_q  <= {EDGE_CNT_W{1'b0}};
      frame_err_q   <= 1'b0;
      stats_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pix_cnt_q     <= pix_cnt_d;
      edge_acc_q    <= edge_acc_d;
      pixel_out_q   <= pixel_out_d;
      valid_out_q   <= valid_out_d;
      edge_count_q  <= edge_count_d;
      frame_err_q   <= frame_err_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign pixel_out   = pixel_out_q;
  assign valid_out   = valid_out_q;
  assign edge_count  = edge_count_q;
  assign frame_err   = frame_err_q;
  assign stats_valid = stats_valid_q;

`ifdef EDGE_BBOX_EN
  logic [COORD_W-1:0] trk_min_row_s, trk_max_row_s, trk_min_col_s, trk_max_col_s;
  logic [COORD_W-1:0] bb_min_row_q, bb_min_row_d, bb_max_row_q, bb_max_row_d;
  logic [COORD_W-1:0] bb_min_col_q, bb_min_col_d, bb_max_col_q, bb_max_col_d;
  logic               bb_valid_q, bb_valid_d;

  edge_bbox_tracker u_bbox (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_s),
    .update  (edge_s),
    .row     (row_q),
    .col     (col_q),
    .min_row (trk_min_row_s),
    .max_row (trk_max_row_s),
    .min_col (trk_min_col_s),
    .max_col (trk_max_col_s)
  );

  // Box outputs are published in REPORT and forced to zero for an edge-free frame.
  always_comb begin
    bb_min_row_d = bb_min_row_q;
    bb_max_row_d = bb_max_row_q;
    bb_min_col_d = bb_min_col_q;
    bb_max_col_d = bb_max_col_q;
    bb_valid_d   = bb_valid_q;
    if (state_q == ST_REPORT) begin
      bb_valid_d   = (edge_acc_q != {EDGE_CNT_W{1'b0}});
      bb_min_row_d = bb_valid_d ? trk_min_row_s : {COORD_W{1'b0}};
      bb_max_row_d = bb_valid_d ? trk_max_row_s : {COORD_W{1'b0}};
      bb_min_col_d = bb_valid_d ? trk_min_col_s : {COORD_W{1'b0}};
      bb_max_col_d = bb_valid_d ? trk_max_col_s : {COORD_W{1'b0}};
    end else begin
      bb_valid_d = bb_valid_q;
    end
  end

  // Published bounding-box registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bb_min_row_q <= {COORD_W{1'b0}};
      bb_max_row_q <= {COORD_W{1'b0}};
      bb_min_col_q <= {COORD_W{1'b0}};
      bb_max_col_q <= {COORD_W{1'b0}};
      bb_valid_q   <= 1'b0;
    end else begin
      bb_min_row_q <= bb_min_row_d;
      bb_max_row_q <= bb_max_row_d;
      bb_min_col_q <= bb_min_col_d;
      bb_max_col_q <= bb_max_col_d;
      bb_valid_q   <= bb_valid_d;
    end
  end

  assign bbox_min_row = bb_min_row_q;
  assign bbox_max_row = bb_max_row_q;
  assign bbox_min_col = bb_min_col_q;
  assign bbox_max_col = bb_max_col_q;
  assign bbox_valid   = bb_valid_q;
`else
  assign bbox_min_row = {COORD_W{1'b0}};
  assign bbox_max_row = {COORD_W{1'b0}};
  assign bbox_min_col = {COORD_W{1'b0}};
  assign bbox_max_col = {COORD_W{1'b0}};
  assign bbox_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_edge_threshold_stats.sv
// Directed plus randomized bench for edge_threshold_stats on a 6x5 image (4x3 output frame).
module tb_edge_threshold_stats;

  localparam int OW = 4;
  localparam int OH = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, valid_in, done_in;
  logic [7:0]  threshold, pixel_in, pixel_out;
  logic        valid_out, bbox_valid, frame_err, stats_valid;
  logic [19:0] edge_count;
  logic [15:0] bbox_min_col, bbox_max_col, bbox_min_row, bbox_max_row;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int pix[16];

  edge_threshold_stats #(.WIDTH(8), .IMG_WIDTH(6), .IMG_HEIGHT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .pixel_in(pixel_in), .valid_in(valid_in), .done_in(done_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .edge_count(edge_count),
    .bbox_min_col(bbox_min_col), .bbox_max_col(bbox_max_col),
    .bbox_min_row(bbox_min_row), .bbox_max_row(bbox_max_row),
    .bbox_valid(bbox_valid), .frame_err(frame_err), .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pixel_out"}, 32'(pixel_out), 32'd0);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, ".edge_count"}, 32'(edge_count), 32'd0);
    chk({tag, ".frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, ".stats_valid"}, 32'(stats_valid), 32'd0);
    chk({tag, ".bbox_valid"}, 32'(bbox_valid), 32'd0);
    chk({tag, ".bbox_or"}, 32'(bbox_min_col | bbox_max_col | bbox_min_row | bbox_max_row), 32'd0);
  endtask

  // Reference: pixel k of the stream sits at col k%OW, row k/OW clamped to the last row.
  task automatic run_frame(input string name, input int thr, input int n, input bit coincide);
    int  exp_edges = 0;
    int  mnr = 0, mxr = 0, mnc = 0, mxc = 0;
    bit  any = 1'b0;
    int  r, c;
    for (int k = 0; k < n; k++) begin
      if (pix[k] >= thr) begin
        r = (k / OW < OH) ? k / OW : OH - 1;
        c = k % OW;
        if (!any) begin
          mnr = r; mxr = r; mnc = c; mxc = c;
        end else begin
          mnr = (r < mnr) ? r : mnr; mxr = (r > mxr) ? r : mxr;
          mnc = (c < mnc) ? c : mnc; mxc = (c > mxc) ? c : mxc;
        end
        any = 1'b1;
        exp_edges++;
      end
    end
`ifndef EDGE_BBOX_EN
    any = 1'b0;
`endif
    if (!any) begin
      mnr = 0; mxr = 0; mnc = 0; mxc = 0;
    end

    @(negedge clk); start = 1'b1; threshold = 8'(thr);
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < n; k++) begin
      valid_in = 1'b1;
      pixel_in = 8'(pix[k]);
      done_in  = coincide && (k == n - 1);
      @(negedge clk);
      chk($sformatf("%s.valid_out[%0d]", name, k), 32'(valid_out), 32'd1);
      chk($sformatf("%s.pixel_out[%0d]", name, k), 32'(pixel_out), (pix[k] >= thr) ? 32'd255 : 32'd0);
    end
    valid_in = 1'b0;
    done_in  = 1'b0;
    if (!coincide) begin
      done_in = 1'b1;
      @(negedge clk);
      done_in = 1'b0;
      chk({name, ".valid_out_idle"}, 32'(valid_out), 32'd0);
    end
    @(negedge clk);
    chk({name, ".stats_valid"}, 32'(stats_valid), 32'd1);
    chk({name, ".edge_count"}, 32'(edge_count), 32'(exp_edges));
    chk({name, ".frame_err"}, 32'(frame_err), (n != OW * OH) ? 32'd1 : 32'd0);
    chk({name, ".bbox_valid"}, 32'(bbox_valid), 32'(any));
    chk({name, ".bbox_min_row"}, 32'(bbox_min_row), 32'(mnr));
    chk({name, ".bbox_max_row"}, 32'(bbox_max_row), 32'(mxr));
    chk({name, ".bbox_min_col"}, 32'(bbox_min_col), 32'(mnc));
    chk({name, ".bbox_max_col"}, 32'(bbox_max_col), 32'(mxc));
    @(negedge clk);
    chk({name, ".stats_pulse_end"}, 32'(stats_valid), 32'd0);
    chk({name, ".edge_count_held"}, 32'(edge_count), 32'(exp_edges));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid_in = 1'b0; done_in = 1'b0;
    threshold = 8'd0; pixel_in = 8'd0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    foreach (pix[k]) pix[k] = 50;
    run_frame("all_below", 100, 12, 1'b0);

    foreach (pix[k]) pix[k] = 0;
    pix[1 * OW + 2] = 200;
    pix[2 * OW + 0] = 100;
    run_frame("two_edges", 100, 12, 1'b0);

    run_frame("short_frame", 100, 11, 1'b0);

    foreach (pix[k]) pix[k] = 0;
    pix[12] = 255;
    run_frame("long_frame_rowsat", 100, 13, 1'b0);

    foreach (pix[k]) pix[k] = (k * 37) % 256;
    run_frame("coincident_done", 128, 12, 1'b1);

    foreach (pix[k]) pix[k] = k * 3;
    run_frame("thr_zero", 0, 12, 1'b0);

    // Reset in the middle of a frame, then traffic without a new start.
    @(negedge clk); start = 1'b1; threshold = 8'd0;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_in = 1'b1; pixel_in = 8'd200;
      @(negedge clk);
    end
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midframe_reset");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1; pixel_in = 8'd255;
      @(negedge clk);
      chk($sformatf("no_start.valid_out[%0d]", k), 32'(valid_out), 32'd0);
    end
    valid_in = 1'b0; done_in = 1'b1;
    @(negedge clk); done_in = 1'b0;
    @(negedge clk);
    chk("no_start.stats_valid", 32'(stats_valid), 32'd0);
    chk("no_start.edge_count", 32'(edge_count), 32'd0);

    for (int it = 0; it < 8; it++) begin
      int n;
      int thr;
      bit co;
      n   = $urandom_range(10, 14);
      thr = $urandom_range(0, 255);
      co  = 1'($urandom_range(0, 1));
      foreach (pix[k]) pix[k] = $urandom_range(0, 255);
      run_frame($sformatf("rand%0d", it), thr, n, co);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/edge_threshold_stats.md
EDGE_THRESHOLD_STATS -- requirements
Module: edge_threshold_stats

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning input gradient pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, meaning source image width; output frame width OUT_W = IMG_WIDTH-2.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, meaning source image height; output frame height OUT_H = IMG_HEIGHT-2.
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning an arm pulse for the next frame.
REQ-007 SHALL have port threshold, input, WIDTH, meaning the edge threshold, sampled on start.
REQ-008 SHALL have port pixel_in, input, WIDTH, meaning the gradient magnitude from the upstream Sobel stage.
REQ-009 SHALL have port valid_in, input, 1, meaning pixel_in is valid this cycle.
REQ-010 SHALL have port done_in, input, 1, meaning the upstream frame-complete pulse.
REQ-011 SHALL have port pixel_out, output, WIDTH, meaning the binarized pixel (0 or all-ones).
REQ-012 SHALL have port valid_out, output, 1, meaning pixel_out is valid.
REQ-013 SHALL have port edge_count, output, 20, meaning the number of edge pixels in the last frame.
REQ-014 SHALL have ports bbox_min_col, bbox_max_col, bbox_min_row and bbox_max_row, each output, 16, meaning the edge bounding box.
REQ-015 SHALL have port bbox_valid, output, 1, meaning at least one edge was found in the last frame.
REQ-016 SHALL have port frame_err, output, 1, meaning the received pixel count != OUT_W*OUT_H.
REQ-017 SHALL have port stats_valid, output, 1, meaning a one-cycle pulse when the stats outputs update.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and REPORT.
REQ-019 SHALL move IDLE->RUN on start, latching threshold and clearing the col, row, pixel, edge and bbox accumulators.
REQ-020 SHALL ignore valid_in and done_in in IDLE, and SHALL ignore start in RUN and REPORT.
REQ-021 SHALL, in RUN on each valid_in, set pixel_out = all-ones if pixel_in >= latched threshold (else 0), with valid_out asserted exactly 1 cycle after valid_in.
REQ-022 SHALL increment col per accepted pixel and wrap it at OUT_W-1 to 0 while incrementing row.
REQ-023 SHALL saturate row at OUT_H-1, and SHALL continue counting pixels beyond OUT_W*OUT_H for error detection, with no wrap to row 0.
REQ-024 SHALL, per edge pixel, increment the edge accumulator and update bbox min/max with the current (row, col).
REQ-025 SHALL move RUN->REPORT on done_in; if valid_in coincides with done_in, that pixel SHALL be counted first.
REQ-026 SHALL, in REPORT (one cycle), register all stats outputs, pulse stats_valid, then go to IDLE.
REQ-027 SHALL hold the stats outputs until the next REPORT.
REQ-028 SHALL set frame_err = 1 in REPORT when the accepted pixel count != OUT_W*OUT_H.
REQ-029 SHALL drive bbox_valid = 0 and all bbox outputs = 0 when the edge count is 0.
REQ-030 SHALL make the edge counter saturate at 2^20-1.

Reset
REQ-031 SHALL, on rst_n low (asynchronous, any state, including mid-frame), set state IDLE and clear all outputs and accumulators to 0.
REQ-032 SHALL resume operation only on a new start after reset release.

Configuration
REQ-033 SHALL, with EDGE_BBOX_EN defined, implement bbox tracking per REQ-024/REQ-029.
REQ-034 SHALL, without EDGE_BBOX_EN, omit the bbox registers and tie the bbox outputs and bbox_valid to 0; all other behaviour SHALL be unchanged.

Structure
REQ-035 SHALL place FSM state encoding, EDGE_CNT_W=20 and COORD_W=16 in shared package edge_pkg.
REQ-036 SHALL use one sub-module, edge_bbox_tracker (min/max coordinate accumulator), instantiated only under EDGE_BBOX_EN.

Verification
REQ-037 SHALL cover: IMG_WIDTH=6, IMG_HEIGHT=5, threshold=100, 12 pixels all 50 then done_in -> 12 valid_out of 0, edge_count=0, bbox_valid=0, frame_err=0, stats_valid pulse.
REQ-038 SHALL cover: same size, pixel at (row 1, col 2)=200 and at (row 2, col 0)=100, others 0 -> edge_count=2, bbox col 0..2, row 1..2, bbox_valid=1.
REQ-039 SHALL cover: 11 pixels then done_in -> frame_err=1; 13 pixels then done_in -> frame_err=1, row saturated at 2.
REQ-040 SHALL cover: last pixel valid_in coincident with done_in -> pixel counted, frame_err=0, valid_out asserted next cycle.
REQ-041 SHALL cover: rst_n low after 5 pixels -> all outputs 0, FSM IDLE, and subsequent pixels without start produce no valid_out.
REQ-042 SHALL cover: threshold=0 -> every pixel outputs 255 and edge_count=12; the build without EDGE_BBOX_EN gives bbox outputs 0.
